ahb2apb_bridge: RTL and testbench

- Single-clock AHB-Lite slave to APB master bridge, directly upstream of the APB peripherals (GPIO, timers, UART).
- Converts each NONSEQ/SEQ AHB transfer into one APB SETUP+ACCESS cycle.
- Decodes a one-hot PSEL per slave and returns the selected slave's PRDATA on HRDATA.
- Unmapped addresses get an AHB two-cycle ERROR response; no APB cycle is issued for them.

---
 rtl/ahb2apb_bridge.sv | 174 +++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
// ----------------------------------------------------------------------------
// ahb2apb_bridge
//
// Single-clock AHB-Lite slave to APB master bridge. Every accepted NONSEQ/SEQ
// AHB transfer becomes exactly one APB SETUP + ACCESS pair. The target slave is
// chosen by the 4-bit index HADDR[DEC_LSB+3:DEC_LSB]. Indices at or above
// NUM_SLV get a two-cycle AHB ERROR response and no APB cycle is issued.
//
// Handshake: an AHB address phase is taken when HSEL & HTRANS[1] & HREADY is
// high while the bridge is in IDLE, DONE or ERR2. In every other state
// HREADYOUT is low, which holds off the master until the transfer completes.
// There is no PREADY; ACCESS always lasts one cycle.
//
// Ports
//   PCLK, PRST_N   shared AHB/APB clock, asynchronous active-low reset
//   HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY   AHB-Lite slave inputs
//   HREADYOUT, HRESP, HRDATA                      AHB-Lite slave outputs
//   PSEL (one-hot), PENABLE, PWRITE, PADDR, PWDATA APB master outputs
//   PRDATA_BUS     slave i read data in bits [32i+31:32i]
//   dbg_state      current FSM state, for observation only
// ----------------------------------------------------------------------------
module ahb2apb_bridge #(
    parameter int NUM_SLV = 4,
    parameter int DEC_LSB = 12
) (
    input  logic                   PCLK,
    input  logic                   PRST_N,
    input  logic                   HSEL,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [31:0]            HADDR,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic [1:0]             HRESP,
    output logic [31:0]            HRDATA,
    output logic [NUM_SLV-1:0]     PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [31:0]            PADDR,
    output logic [31:0]            PWDATA,
    input  logic [NUM_SLV*32-1:0]  PRDATA_BUS,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    // Widened to 5 bits so NUM_SLV=16 compares correctly against a 4-bit index.
    localparam logic [4:0] NUM_SLV_W = 5'(NUM_SLV);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  addr_idx;
    logic        accept;
    logic        take;
    logic        sel_active;
    logic [31:0] rd_slice;
    state_t      accept_nxt;

    // HTRANS[0] only distinguishes NONSEQ from SEQ, which the bridge treats alike.
    logic        unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    assign addr_idx  = HADDR[DEC_LSB+3:DEC_LSB];
    assign accept    = HSEL & HTRANS[1] & HREADY;
    assign dbg_state = state;

    // Destination of a freshly accepted address phase.
    always_comb begin
        accept_nxt = S_SETUP;
        if ({1'b0, addr_idx} >= NUM_SLV_W) begin
            accept_nxt = S_ERR1;
        end else if (HWRITE) begin
            accept_nxt = S_WDATA;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        HREADYOUT  = 1'b1;
        HRESP      = 2'b00;
        PENABLE    = 1'b0;
        sel_active = 1'b0;
        take       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                take = accept;
                if (accept) state_nxt = accept_nxt;
                else        state_nxt = S_IDLE;
            end
            S_WDATA: begin
                HREADYOUT = 1'b0;
                state_nxt = S_SETUP;
            end
            S_SETUP: begin
                HREADYOUT  = 1'b0;
                sel_active = 1'b1;
                state_nxt  = S_ACCESS;
            end
            S_ACCESS: begin
                HREADYOUT  = 1'b0;
                sel_active = 1'b1;
                PENABLE    = 1'b1;
                state_nxt  = S_DONE;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                HRESP = 2'b01;
                take  = accept;
                if (accept) state_nxt = accept_nxt;
                else        state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // One-hot select; idx is always a valid slave while sel_active is high.
    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_active && (idx == 4'(i))) PSEL[i] = 1'b1;
        end
    end

    // Read-data mux over the slave bus.
    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == 4'(i)) rd_slice = PRDATA_BUS[i*32 +: 32];
        end
    end

    always_ff @(posedge PCLK or negedge PRST_N) begin
        if (!PRST_N) begin
            state  <= S_IDLE;
            idx    <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            HRDATA <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                idx    <= addr_idx;
            end
            // HWDATA is valid in the AHB data phase, which is the WDATA cycle.
            if (state == S_WDATA) begin
                PWDATA <= HWDATA;
            end
            if ((state == S_ACCESS) && !PWRITE) begin
                HRDATA <= rd_slice;
            end
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// ----------------------------------------------------------------------------
// tb_ahb2apb_bridge
//
// Directed bench for ahb2apb_bridge (NUM_SLV=4, DEC_LSB=12). Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point, so each
// check sees the state entered on the preceding edge. Cycle names follow the
// address phase T0 of each transfer.
// ----------------------------------------------------------------------------
module tb_ahb2apb_bridge;

    localparam int NUM_SLV = 4;

    logic                  PCLK;
    logic                  PRST_N;
    logic                  HSEL;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [31:0]           HADDR;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [31:0]           HRDATA;
    logic [NUM_SLV-1:0]    PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PADDR;
    logic [31:0]           PWDATA;
    logic [NUM_SLV*32-1:0] PRDATA_BUS;
    logic [2:0]            dbg_state;

    int n_compared;
    int n_mismatched;

    ahb2apb_bridge #(.NUM_SLV(NUM_SLV), .DEC_LSB(12)) dut (
        .PCLK      (PCLK),
        .PRST_N    (PRST_N),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA_BUS(PRDATA_BUS),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive_addr(input logic wr, input logic [31:0] addr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = addr;
    endtask

    task automatic drive_idle();
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Compact view of the status outputs: {HREADYOUT, HRESP, PENABLE, PSEL}
    function automatic logic [31:0] status();
        return {24'd0, HREADYOUT, HRESP, PENABLE, PSEL};
    endfunction

    function automatic logic [31:0] st(input logic rdy, input logic [1:0] resp,
                                       input logic en, input logic [3:0] sel);
        return {24'd0, rdy, resp, en, sel};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        PRST_N     = 1'b0;
        HSEL       = 1'b0;
        HTRANS     = 2'b00;
        HWRITE     = 1'b0;
        HADDR      = '0;
        HWDATA     = '0;
        HREADY     = 1'b1;
        PRDATA_BUS = {32'hCAFE_0003, 32'hBEEF_0002, 32'h1234_5678, 32'hDEAD_0000};

        step();
        step();
        check_eq("rst_status", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));
        check_eq("rst_paddr",  PADDR,  32'h0);
        check_eq("rst_pwdata", PWDATA, 32'h0);
        check_eq("rst_hrdata", HRDATA, 32'h0);
        check_eq("rst_pwrite", {31'd0, PWRITE}, 32'h0);
        PRST_N = 1'b1;

        // Selected but IDLE/BUSY transfers: nothing happens.
        HSEL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            HTRANS = (i % 2 == 0) ? 2'b00 : 2'b01;
            HADDR  = 32'h0000_0010;
            step();
            check_eq($sformatf("idle_%0d", i), status(), st(1'b1, 2'b00, 1'b0, 4'b0000));
        end

        // Write to slave 0: T0 address, T1 data, T2 SETUP, T3 ACCESS, T4 DONE.
        drive_addr(1'b1, 32'h0000_0018);
        step();                                                   // T1
        drive_idle();
        HWDATA = 32'hA5A5_0F0F;
        check_eq("wr_t1_status", status(), st(1'b0, 2'b00, 1'b0, 4'b0000));
        step();                                                   // T2
        check_eq("wr_t2_status", status(), st(1'b0, 2'b00, 1'b0, 4'b0001));
        step();                                                   // T3
        check_eq("wr_t3_status", status(), st(1'b0, 2'b00, 1'b1, 4'b0001));
        check_eq("wr_t3_paddr",  PADDR,  32'h0000_0018);
        check_eq("wr_t3_pwrite", {31'd0, PWRITE}, 32'h1);
        check_eq("wr_t3_pwdata", PWDATA, 32'hA5A5_0F0F);
        step();                                                   // T4
        check_eq("wr_t4_status", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));
        check_eq("wr_t4_hrdata", HRDATA, 32'h0);

        // Read from slave 1.
        drive_addr(1'b0, 32'h0000_1018);
        step();                                                   // T1
        drive_idle();
        check_eq("rd_t1_status", status(), st(1'b0, 2'b00, 1'b0, 4'b0010));
        step();                                                   // T2
        check_eq("rd_t2_status", status(), st(1'b0, 2'b00, 1'b1, 4'b0010));
        check_eq("rd_t2_pwdata", PWDATA, 32'hA5A5_0F0F);
        step();                                                   // T3
        check_eq("rd_t3_status", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));
        check_eq("rd_t3_hrdata", HRDATA, 32'h1234_5678);

        // Unmapped index 4: two-cycle ERROR, no APB select.
        drive_addr(1'b0, 32'h0000_4000);
        step();                                                   // T1
        drive_idle();
        check_eq("err_t1_status", status(), st(1'b0, 2'b01, 1'b0, 4'b0000));
        step();                                                   // T2
        check_eq("err_t2_status", status(), st(1'b1, 2'b01, 1'b0, 4'b0000));
        check_eq("err_t2_hrdata", HRDATA, 32'h1234_5678);
        step();                                                   // T3
        check_eq("err_t3_status", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));

        // Back-to-back: write 0x1C, then read 0x18 issued in the write's DONE.
        drive_addr(1'b1, 32'h0000_001C);
        step();                                                   // T1
        drive_idle();
        HWDATA = 32'h0BAD_F00D;
        step();                                                   // T2
        step();                                                   // T3
        check_eq("b2b_wr_paddr",  PADDR,  32'h0000_001C);
        check_eq("b2b_wr_pwdata", PWDATA, 32'h0BAD_F00D);
        step();                                                   // T4 DONE
        check_eq("b2b_done_status", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));
        drive_addr(1'b0, 32'h0000_0018);
        step();                                                   // SETUP of the read
        drive_idle();
        check_eq("b2b_rd_setup", status(), st(1'b0, 2'b00, 1'b0, 4'b0001));
        check_eq("b2b_rd_paddr", PADDR, 32'h0000_0018);
        check_eq("b2b_rd_pwrite", {31'd0, PWRITE}, 32'h0);
        step();                                                   // ACCESS
        check_eq("b2b_rd_access", status(), st(1'b0, 2'b00, 1'b1, 4'b0001));
        step();                                                   // DONE
        check_eq("b2b_rd_hrdata", HRDATA, 32'hDEAD_0000);
        check_eq("b2b_rd_done", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));

        // Reset pulsed during ACCESS of a read from slave 2.
        drive_addr(1'b0, 32'h0000_2000);
        step();                                                   // SETUP
        drive_idle();
        step();                                                   // ACCESS
        check_eq("rst_mid_access", status(), st(1'b0, 2'b00, 1'b1, 4'b0100));
        #2;
        PRST_N = 1'b0;
        #1;
        check_eq("rst_mid_status", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));
        check_eq("rst_mid_hrdata", HRDATA, 32'h0);
        check_eq("rst_mid_paddr",  PADDR,  32'h0);
        #1;
        PRST_N = 1'b1;
        step();
        check_eq("rst_after_hrdata", HRDATA, 32'h0);
        check_eq("rst_after_status", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));

        // Normal read from slave 3 after the reset.
        drive_addr(1'b0, 32'h0000_3004);
        step();
        drive_idle();
        check_eq("post_rst_setup", status(), st(1'b0, 2'b00, 1'b0, 4'b1000));
        step();
        check_eq("post_rst_access", status(), st(1'b0, 2'b00, 1'b1, 4'b1000));
        step();
        check_eq("post_rst_hrdata", HRDATA, 32'hCAFE_0003);
        check_eq("post_rst_paddr",  PADDR,  32'h0000_3004);
        check_eq("post_rst_done", status(), st(1'b1, 2'b00, 1'b0, 4'b0000));

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
